// File: rtl/knn_train_loader.sv
// Writer side of the KNN training memory: unpacks a framed byte stream
// (SYNC, N_lo, N_hi, 4*N data bytes, XOR checksum) into 32-bit RAM writes.
module knn_train_loader #(
  parameter int         ADDR_W  = 10,
  parameter int         DEPTH   = 1024,
  parameter logic [7:0] SYNC    = 8'hA5,
  parameter int         TIMEOUT = 50000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic [7:0]        byte_data,
  input  logic              byte_valid,
  output logic              byte_ready,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [31:0]       wr_data,
  output logic              busy,
  output logic              load_done,
  output logic              load_err,
  output logic [1:0]        err_code,
  output logic [ADDR_W:0]   sample_count
);

  localparam int          IDX_W   = ADDR_W + 1;
  localparam int          TMO_W   = $clog2(TIMEOUT + 1);
  localparam logic [15:0] DEPTH_N = 16'(DEPTH);

  typedef enum logic [2:0] {S_IDLE, S_CNT_LO, S_CNT_HI, S_DATA, S_CHECK} state_t;
  typedef enum logic [1:0] {ERR_NONE, ERR_COUNT, ERR_CHK, ERR_TMO} err_t;

  state_t            state_q;
  logic [15:0]       n_q;
  logic [IDX_W-1:0]  idx_q;
  logic [1:0]        lane_q;
  logic [23:0]       word_q;
  logic [7:0]        chk_q;
  logic [TMO_W-1:0]  tmo_q;
  logic              wr_en_q;
  logic [ADDR_W-1:0] wr_addr_q;
  logic [31:0]       wr_data_q;
  logic              done_q;
  logic              err_q;
  err_t              code_q;
  logic [IDX_W-1:0]  count_q;

  logic        accept;
  logic [15:0] n_full;
  logic        last_word;
  logic        tmo_hit;

  // Holding off the byte stream during clear keeps the host from losing a byte.
  assign byte_ready = ~clear;
  assign accept     = byte_valid & ~clear;
  assign n_full     = {byte_data, n_q[7:0]};
  assign last_word  = (16'(idx_q) + 16'd1) == n_q;
  assign tmo_hit    = (tmo_q == TMO_W'(TIMEOUT - 1)) && !accept;

  // NOTE: every register here is state updated on the clock edge, so all
  // assignments are non-blocking; blocking ones would create ordering races.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      n_q       <= '0;
      idx_q     <= '0;
      lane_q    <= '0;
      word_q    <= '0;
      chk_q     <= '0;
      tmo_q     <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      code_q    <= ERR_NONE;
      count_q   <= '0;
    end else begin
      wr_en_q <= 1'b0;
      if (clear) begin
        state_q <= S_IDLE;
        n_q     <= '0;
        idx_q   <= '0;
        lane_q  <= '0;
        word_q  <= '0;
        chk_q   <= '0;
        tmo_q   <= '0;
        done_q  <= 1'b0;
        err_q   <= 1'b0;
        code_q  <= ERR_NONE;
      end else if (state_q != S_IDLE && tmo_hit) begin
        state_q <= S_IDLE;
        tmo_q   <= '0;
        err_q   <= 1'b1;
        code_q  <= ERR_TMO;
      end else begin
        if (state_q == S_IDLE || accept) tmo_q <= '0;
        else                             tmo_q <= tmo_q + TMO_W'(1);

        if (accept) begin
          unique case (state_q)
            S_IDLE: begin
              if (byte_data == SYNC) begin
                done_q  <= 1'b0;
                err_q   <= 1'b0;
                code_q  <= ERR_NONE;
                state_q <= S_CNT_LO;
              end
            end
            S_CNT_LO: begin
              n_q[7:0] <= byte_data;
              state_q  <= S_CNT_HI;
            end
            S_CNT_HI: begin
              n_q <= n_full;
              if (n_full == 16'd0 || n_full > DEPTH_N) begin
                err_q   <= 1'b1;
                code_q  <= ERR_COUNT;
                state_q <= S_IDLE;
              end else begin
                idx_q   <= '0;
                lane_q  <= '0;
                chk_q   <= '0;
                state_q <= S_DATA;
              end
            end
            S_DATA: begin
              chk_q  <= chk_q ^ byte_data;
              lane_q <= lane_q + 2'd1;
              // Lower lanes shift in from the top so lane 0 ends up in bits [7:0].
              word_q <= {byte_data, word_q[23:8]};
              if (lane_q == 2'd3) begin
                wr_en_q   <= 1'b1;
                wr_addr_q <= idx_q[ADDR_W-1:0];
                wr_data_q <= {byte_data, word_q};
                idx_q     <= idx_q + IDX_W'(1);
                if (last_word) state_q <= S_CHECK;
              end
            end
            S_CHECK: begin
              if (byte_data == chk_q) begin
                done_q  <= 1'b1;
                count_q <= n_q[IDX_W-1:0];
              end else begin
                err_q  <= 1'b1;
                code_q <= ERR_CHK;
              end
              state_q <= S_IDLE;
            end
            default: state_q <= S_IDLE;
          endcase
        end
      end
    end
  end

  assign wr_en        = wr_en_q;
  assign wr_addr      = wr_addr_q;
  assign wr_data      = wr_data_q;
  assign busy         = (state_q != S_IDLE);
  assign load_done    = done_q;
  assign load_err     = err_q;
  assign err_code     = code_q;
  assign sample_count = count_q;

endmodule

// File: tb/tb_knn_train_loader.sv
// Self-checking bench for knn_train_loader: frame table plus hand-written
// sequences for latency, timeout, backpressure, clear and reset.
module tb_knn_train_loader;

  localparam int ADDR_W = 10;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              clear = 1'b0;
  logic [7:0]        byte_data = '0;
  logic              byte_valid = 1'b0;
  logic              byte_ready;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [31:0]       wr_data;
  logic              busy;
  logic              load_done;
  logic              load_err;
  logic [1:0]        err_code;
  logic [ADDR_W:0]   sample_count;

  knn_train_loader #(.ADDR_W(ADDR_W), .DEPTH(1024), .SYNC(8'hA5), .TIMEOUT(16)) dut (
    .clk(clk), .rst(rst), .clear(clear),
    .byte_data(byte_data), .byte_valid(byte_valid), .byte_ready(byte_ready),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .busy(busy), .load_done(load_done), .load_err(load_err),
    .err_code(err_code), .sample_count(sample_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [31:0]       data;
  } wr_t;

  typedef struct packed {
    logic [0:15][7:0] bytes;
    logic [7:0]       len;
    logic [7:0]       doff;
    logic [7:0]       nw;
    logic             done;
    logic             err;
    logic [1:0]       code;
    logic [10:0]      count;
  } vec_t;

  wr_t  exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   wr_count = 0;
  vec_t tbl [5];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Scoreboard: every write the DUT issues must match the oldest expected one.
  always @(negedge clk) begin
    if (!rst && wr_en) begin
      wr_count++;
      if (exp_q.size() == 0) begin
        check("unexpected_write_addr", 32'(wr_addr), 32'hFFFF_FFFF);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        check("wr_addr", 32'(wr_addr), 32'(e.addr));
        check("wr_data", wr_data, e.data);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic send_byte(input logic [7:0] b);
    byte_valid = 1'b1;
    byte_data  = b;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    byte_valid = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push_wr(input int addr, input logic [31:0] data);
    wr_t e;
    e.addr = ADDR_W'(addr);
    e.data = data;
    exp_q.push_back(e);
  endtask

  task automatic check_flags(input string tag, input logic done, input logic err,
                             input logic [1:0] code, input int count);
    check({tag, "_busy"},  32'(busy),         32'd0);
    check({tag, "_done"},  32'(load_done),    32'(done));
    check({tag, "_err"},   32'(load_err),     32'(err));
    check({tag, "_code"},  32'(err_code),     32'(code));
    check({tag, "_count"}, 32'(sample_count), 32'(count));
  endtask

  task automatic send_good_frame2();
    push_wr(0, 32'h0403_0201);
    push_wr(1, 32'h4030_2010);
    foreach (tbl[0].bytes[i]) if (i < 12) send_byte(tbl[0].bytes[i]);
    idle(2);
  endtask

  initial begin
    logic [7:0] d [12];
    logic [7:0] chk;
    int         base;

    tbl[0] = '{bytes: 128'hA5020001_02030410_20304044_00000000, len: 12, doff: 3, nw: 2,
               done: 1'b1, err: 1'b0, code: 2'd0, count: 11'd2};
    tbl[1] = '{bytes: 128'hA5020001_02030410_20304045_00000000, len: 12, doff: 3, nw: 2,
               done: 1'b0, err: 1'b1, code: 2'd2, count: 11'd2};
    tbl[2] = '{bytes: 128'hA5000000_00000000_00000000_00000000, len: 3, doff: 3, nw: 0,
               done: 1'b0, err: 1'b1, code: 2'd1, count: 11'd2};
    tbl[3] = '{bytes: 128'hA5010400_00000000_00000000_00000000, len: 3, doff: 3, nw: 0,
               done: 1'b0, err: 1'b1, code: 2'd1, count: 11'd2};
    tbl[4] = '{bytes: 128'h00FF5AA5_0100A511_2233A500_00000000, len: 11, doff: 6, nw: 1,
               done: 1'b1, err: 1'b0, code: 2'd0, count: 11'd1};

    // Reset values
    #12;
    check("rst_ready",   32'(byte_ready), 32'd1);
    check("rst_wr_en",   32'(wr_en),      32'd0);
    check("rst_wr_addr", 32'(wr_addr),    32'd0);
    check("rst_wr_data", wr_data,         32'd0);
    check_flags("rst", 1'b0, 1'b0, 2'd0, 0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Good frame with write latency checked right after each fourth byte
    push_wr(0, 32'h0403_0201);
    push_wr(1, 32'h4030_2010);
    send_byte(8'hA5); send_byte(8'h02); send_byte(8'h00);
    check("busy_in_frame", 32'(busy), 32'd1);
    send_byte(8'h01); send_byte(8'h02); send_byte(8'h03);
    check("no_early_wr", 32'(wr_en), 32'd0);
    send_byte(8'h04);
    check("wr0_latency", 32'(wr_en), 32'd1);
    check("wr0_data",    wr_data,    32'h0403_0201);
    send_byte(8'h10); send_byte(8'h20); send_byte(8'h30); send_byte(8'h40);
    check("wr1_latency", 32'(wr_en), 32'd1);
    check("wr1_addr",    32'(wr_addr), 32'd1);
    send_byte(8'h44);
    idle(2);
    check_flags("good", 1'b1, 1'b0, 2'd0, 2);

    // Table of whole frames
    for (int r = 0; r < 5; r++) begin
      for (int k = 0; k < int'(tbl[r].nw); k++) begin
        base = int'(tbl[r].doff) + 4 * k;
        push_wr(k, {tbl[r].bytes[base + 3], tbl[r].bytes[base + 2],
                    tbl[r].bytes[base + 1], tbl[r].bytes[base]});
      end
      for (int i = 0; i < int'(tbl[r].len); i++) send_byte(tbl[r].bytes[i]);
      idle(2);
      check_flags($sformatf("row%0d", r), tbl[r].done, tbl[r].err, tbl[r].code,
                  int'(tbl[r].count));
    end

    // clear after an error frame, then clear after a good frame
    send_byte(8'hA5); send_byte(8'h00); send_byte(8'h00);
    idle(1);
    check("pre_clear_err", 32'(load_err), 32'd1);
    clear = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0;
    check_flags("clear_err", 1'b0, 1'b0, 2'd0, 1);

    // Timeout: 15 idle cycles are tolerated, the 16th aborts
    send_byte(8'hA5); send_byte(8'h01); send_byte(8'h00); send_byte(8'hAA);
    idle(15);
    check("tmo_not_yet_err",  32'(load_err), 32'd0);
    check("tmo_not_yet_busy", 32'(busy),     32'd1);
    idle(1);
    check_flags("timeout", 1'b0, 1'b1, 2'd3, 1);
    send_good_frame2();
    check_flags("after_tmo", 1'b1, 1'b0, 2'd0, 2);

    // Backpressure: N=3 frame with random gaps between bytes
    chk = '0;
    for (int i = 0; i < 12; i++) begin
      d[i] = 8'(8'h30 + 8'(i * 7));
      chk  = chk ^ d[i];
    end
    for (int k = 0; k < 3; k++) push_wr(k, {d[4*k+3], d[4*k+2], d[4*k+1], d[4*k]});
    wr_count = 0;
    send_byte(8'hA5); send_byte(8'h03); send_byte(8'h00);
    for (int i = 0; i < 13; i++) begin
      idle($urandom_range(0, 3));
      send_byte(i < 12 ? d[i] : chk);
    end
    idle(2);
    check("bp_write_count", 32'(wr_count), 32'd3);
    check_flags("bp", 1'b1, 1'b0, 2'd0, 3);
    clear = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0;
    check_flags("clear_done", 1'b0, 1'b0, 2'd0, 3);

    // N=1024 is accepted; clear during DATA while a write is in flight
    send_byte(8'hA5); send_byte(8'h00); send_byte(8'h04);
    check("n_max_no_err", 32'(load_err), 32'd0);
    check("n_max_busy",   32'(busy),     32'd1);
    push_wr(0, 32'hDDCC_BBAA);
    send_byte(8'hAA); send_byte(8'hBB); send_byte(8'hCC); send_byte(8'hDD);
    wr_count = 0;
    clear      = 1'b1;
    byte_valid = 1'b1;
    byte_data  = 8'hEE;
    #1;
    check("clear_ready", 32'(byte_ready), 32'd0);
    @(posedge clk); #1;
    clear      = 1'b0;
    byte_valid = 1'b0;
    check("clear_wr_completed", 32'(wr_count), 32'd1);
    check_flags("clear_data", 1'b0, 1'b0, 2'd0, 3);

    // Asynchronous reset mid-frame discards the partial word
    send_byte(8'hA5); send_byte(8'h02); send_byte(8'h00);
    send_byte(8'h99); send_byte(8'h88);
    byte_valid = 1'b0;
    rst = 1'b1;
    #2;
    check("mid_rst_ready",   32'(byte_ready), 32'd1);
    check("mid_rst_wr_data", wr_data,         32'd0);
    check("mid_rst_wr_addr", 32'(wr_addr),    32'd0);
    check_flags("mid_rst", 1'b0, 1'b0, 2'd0, 0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    send_good_frame2();
    check_flags("post_rst", 1'b1, 1'b0, 2'd0, 2);

    idle(3);
    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
